// File: rtl/ldl_cdc_edge_filter.sv
// Glitch filter for a synchronized single-bit level: a change is accepted after FILTER equal samples.
// Optional accepted-edge counter is built when LDL_CDC_EDGE_FILTER_CNT_EN is defined.
module ldl_cdc_edge_filter #(
    parameter int   FILTER = 4,
    parameter logic INIT   = 1'b0,
    parameter int   CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    output logic             dout,
    output logic             rise,
    output logic             fall,
    output logic             edge_p,
    output logic             glitch,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] edge_cnt
);

    localparam int RUN_W = ($clog2(FILTER + 1) < 1) ? 1 : $clog2(FILTER + 1);

    typedef enum logic [1:0] {
        STABLE_LOW,
        CHK_HIGH,
        STABLE_HIGH,
        CHK_LOW
    } state_t;

    localparam state_t           RESET_STATE = INIT ? STABLE_HIGH : STABLE_LOW;
    localparam logic [RUN_W-1:0] LAST        = RUN_W'(FILTER - 1);
    localparam logic [RUN_W-1:0] ONE         = RUN_W'(1);

    state_t           state, state_nx;
    logic [RUN_W-1:0] run, run_nx;
    logic             dout_nx, rise_nx, fall_nx, glitch_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= RESET_STATE;
            run    <= '0;
            dout   <= INIT;
            rise   <= 1'b0;
            fall   <= 1'b0;
            edge_p <= 1'b0;
            glitch <= 1'b0;
        end else begin
            state  <= state_nx;
            run    <= run_nx;
            dout   <= dout_nx;
            rise   <= rise_nx;
            fall   <= fall_nx;
            edge_p <= rise_nx | fall_nx;
            glitch <= glitch_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        run_nx    = run;
        dout_nx   = dout;
        rise_nx   = 1'b0;
        fall_nx   = 1'b0;
        glitch_nx = 1'b0;
        case (state)
            STABLE_LOW: begin
                if (din) begin
                    if (FILTER == 1) begin
                        state_nx = STABLE_HIGH;
                        dout_nx  = 1'b1;
                        rise_nx  = 1'b1;
                    end else begin
                        state_nx = CHK_HIGH;
                        run_nx   = ONE;
                    end
                end
            end
            CHK_HIGH: begin
                if (!din) begin
                    state_nx  = STABLE_LOW;
                    run_nx    = '0;
                    glitch_nx = 1'b1;
                end else if (run == LAST) begin
                    state_nx = STABLE_HIGH;
                    run_nx   = '0;
                    dout_nx  = 1'b1;
                    rise_nx  = 1'b1;
                end else begin
                    run_nx = run + ONE;
                end
            end
            STABLE_HIGH: begin
                if (!din) begin
                    if (FILTER == 1) begin
                        state_nx = STABLE_LOW;
                        dout_nx  = 1'b0;
                        fall_nx  = 1'b1;
                    end else begin
                        state_nx = CHK_LOW;
                        run_nx   = ONE;
                    end
                end
            end
            CHK_LOW: begin
                if (din) begin
                    state_nx  = STABLE_HIGH;
                    run_nx    = '0;
                    glitch_nx = 1'b1;
                end else if (run == LAST) begin
                    state_nx = STABLE_LOW;
                    run_nx   = '0;
                    dout_nx  = 1'b0;
                    fall_nx  = 1'b1;
                end else begin
                    run_nx = run + ONE;
                end
            end
            default: begin
                state_nx = RESET_STATE;
                run_nx   = '0;
            end
        endcase
    end

`ifdef LDL_CDC_EDGE_FILTER_CNT_EN
    // Counts the registered edge_p, so edge_cnt lags the pulse by one cycle; clear has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt <= '0;
        end else if (cnt_clr) begin
            edge_cnt <= '0;
        end else if (edge_p && (edge_cnt != {CNT_W{1'b1}})) begin
            edge_cnt <= edge_cnt + CNT_W'(1);
        end
    end
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign edge_cnt       = '0;
`endif

endmodule

// File: tb/tb_ldl_cdc_edge_filter.sv
// Bench for ldl_cdc_edge_filter: four instances (FILTER 4/1/8/3) share din and are compared
// against a sample-history model of the acceptance rules.
module tb_ldl_cdc_edge_filter;

    localparam int N     = 4;
    localparam int CNT_W = 2;

    logic clk;
    logic rst_n;
    logic din;
    logic cnt_clr;

    logic [N-1:0]     dout_v, rise_v, fall_v, edge_v, glitch_v;
    logic [CNT_W-1:0] cnt_v [N];

    int   filt   [N] = '{4, 1, 8, 3};
    logic init_v [N] = '{1'b0, 1'b0, 1'b0, 1'b1};

    // model state
    logic [15:0]      m_hist [N];
    int               m_nhist [N];
    logic             m_dout [N], m_rise [N], m_fall [N], m_edge [N], m_glitch [N];
    logic [CNT_W-1:0] m_cnt [N];

    int checks;
    int errors;

    ldl_cdc_edge_filter #(.FILTER(4), .INIT(1'b0), .CNT_W(CNT_W)) u_f4 (
        .clk(clk), .rst_n(rst_n), .din(din), .dout(dout_v[0]), .rise(rise_v[0]), .fall(fall_v[0]),
        .edge_p(edge_v[0]), .glitch(glitch_v[0]), .cnt_clr(cnt_clr), .edge_cnt(cnt_v[0]));
    ldl_cdc_edge_filter #(.FILTER(1), .INIT(1'b0), .CNT_W(CNT_W)) u_f1 (
        .clk(clk), .rst_n(rst_n), .din(din), .dout(dout_v[1]), .rise(rise_v[1]), .fall(fall_v[1]),
        .edge_p(edge_v[1]), .glitch(glitch_v[1]), .cnt_clr(cnt_clr), .edge_cnt(cnt_v[1]));
    ldl_cdc_edge_filter #(.FILTER(8), .INIT(1'b0), .CNT_W(CNT_W)) u_f8 (
        .clk(clk), .rst_n(rst_n), .din(din), .dout(dout_v[2]), .rise(rise_v[2]), .fall(fall_v[2]),
        .edge_p(edge_v[2]), .glitch(glitch_v[2]), .cnt_clr(cnt_clr), .edge_cnt(cnt_v[2]));
    ldl_cdc_edge_filter #(.FILTER(3), .INIT(1'b1), .CNT_W(CNT_W)) u_f3 (
        .clk(clk), .rst_n(rst_n), .din(din), .dout(dout_v[3]), .rise(rise_v[3]), .fall(fall_v[3]),
        .edge_p(edge_v[3]), .glitch(glitch_v[3]), .cnt_clr(cnt_clr), .edge_cnt(cnt_v[3]));

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_hist[i]   = '0;
            m_nhist[i]  = 0;
            m_dout[i]   = init_v[i];
            m_rise[i]   = 1'b0;
            m_fall[i]   = 1'b0;
            m_edge[i]   = 1'b0;
            m_glitch[i] = 1'b0;
            m_cnt[i]    = '0;
        end
    endtask

    // One clock edge of the reference: a change is taken when the last FILTER samples all differ
    // from the current level; a glitch is a sample back at the level right after a differing one.
    task automatic model_edge(input logic d, input logic clr);
        bit all_diff;
        for (int i = 0; i < N; i++) begin
`ifdef LDL_CDC_EDGE_FILTER_CNT_EN
            if (clr) m_cnt[i] = '0;
            else if (m_edge[i] && m_cnt[i] != {CNT_W{1'b1}}) m_cnt[i] = m_cnt[i] + 1'b1;
`else
            m_cnt[i] = '0;
            if (clr) m_cnt[i] = '0;
`endif
            m_hist[i]  = {m_hist[i][14:0], d};
            if (m_nhist[i] < 1000) m_nhist[i]++;
            m_rise[i]   = 1'b0;
            m_fall[i]   = 1'b0;
            m_glitch[i] = 1'b0;
            all_diff = (m_nhist[i] >= filt[i]);
            for (int b = 0; b < filt[i]; b++)
                if (m_hist[i][b] == m_dout[i]) all_diff = 0;
            if (all_diff) begin
                m_dout[i] = ~m_dout[i];
                if (m_dout[i]) m_rise[i] = 1'b1;
                else           m_fall[i] = 1'b1;
            end else if (m_nhist[i] >= 2 && m_hist[i][0] == m_dout[i] && m_hist[i][1] != m_dout[i]) begin
                m_glitch[i] = 1'b1;
            end
            m_edge[i] = m_rise[i] | m_fall[i];
        end
    endtask

    task automatic chk(input string tag, input int i, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s[inst%0d] t=%0t got %0h expected %0h", tag, i, $time, got, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < N; i++) begin
            chk("dout",     i, {7'd0, dout_v[i]},   {7'd0, m_dout[i]});
            chk("rise",     i, {7'd0, rise_v[i]},   {7'd0, m_rise[i]});
            chk("fall",     i, {7'd0, fall_v[i]},   {7'd0, m_fall[i]});
            chk("edge_p",   i, {7'd0, edge_v[i]},   {7'd0, m_edge[i]});
            chk("glitch",   i, {7'd0, glitch_v[i]}, {7'd0, m_glitch[i]});
            chk("edge_cnt", i, {6'd0, cnt_v[i]},    {6'd0, m_cnt[i]});
        end
    endtask

    // driver: called at a falling edge; applies inputs, advances the model at the rising edge
    task automatic step(input logic d, input logic clr);
        din     = d;
        cnt_clr = clr;
        @(posedge clk);
        if (rst_n) model_edge(d, clr);
        else       model_reset();
        @(negedge clk);
        check_all();
    endtask

    task automatic hold(input logic d, input int n);
        for (int k = 0; k < n; k++) step(d, 1'b0);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        din     = 1'b1;
        cnt_clr = 1'b0;
        model_reset();

        // reset held with din=1
        @(negedge clk);
        hold(1'b1, 3);
        rst_n = 1'b1;

        // clean rise then fall
        hold(1'b1, 10);
        hold(1'b0, 10);

        // 3-sample and 1-sample pulses
        hold(1'b1, 3);
        hold(1'b0, 6);
        hold(1'b1, 1);
        hold(1'b0, 6);

        // toggle every cycle
        for (int k = 0; k < 12; k++) step(k[0] ? 1'b0 : 1'b1, 1'b0);
        hold(1'b0, 10);

        // async reset mid-check, then full acceptance from release
        hold(1'b1, 5);
        #1 rst_n = 1'b0;
        #1 model_reset();
        check_all();
        #1 rst_n = 1'b1;
        hold(1'b1, 10);
        hold(1'b0, 10);

        // counter: several accepted edges, then clear coincident with an edge pulse
        for (int e = 0; e < 5; e++) hold(e[0] ? 1'b0 : 1'b1, 10);
        hold(1'b0, 3);
        step(1'b0, 1'b1);
        hold(1'b0, 2);

        // random runs with occasional clears
        for (int r = 0; r < 120; r++) begin
            logic d;
            int   len;
            d   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 10);
            for (int k = 0; k < len; k++) step(d, ($urandom_range(0, 15) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
